reg_writeback: RTL and testbench

Writeback stage that owns the register-file write port (`wen`, `regWAddr`, `regWData`). It retires ALU results from execute through a valid/ready handshake and returns in-order load data from the memory response channel. Loads are tracked in a small in-order load queue, and a pending-register mask is exported so decode can stall on outstanding load destinations. The register file itself is unchanged; this block is its only writer.

---
 rtl/reg_writeback_if.sv | 31 +++
 rtl/reg_writeback.sv | 99 +++++++++
 tb/tb_reg_writeback.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/reg_writeback_if.sv
// Writeback-stage bus: execute retire handshake, memory response channel,
// register-file write port and load-queue status.
interface reg_writeback_if #(
  parameter int unsigned LQ_DEPTH = 4
);
  localparam int unsigned CW = $clog2(LQ_DEPTH) + 1;

  logic          ex_valid;
  logic          ex_ready;
  logic          ex_is_load;
  logic [4:0]    ex_rd;
  logic [31:0]   ex_data;
  logic          mem_rsp_valid;
  logic [31:0]   mem_rsp_data;
  logic          wen;
  logic [4:0]    regWAddr;
  logic [31:0]   regWData;
  logic [31:0]   pend_mask;
  logic [CW-1:0] lq_count;
  logic          err_orphan;

  modport slave (
    input  ex_valid, ex_is_load, ex_rd, ex_data, mem_rsp_valid, mem_rsp_data,
    output ex_ready, wen, regWAddr, regWData, pend_mask, lq_count, err_orphan
  );

  modport master (
    output ex_valid, ex_is_load, ex_rd, ex_data, mem_rsp_valid, mem_rsp_data,
    input  ex_ready, wen, regWAddr, regWData, pend_mask, lq_count, err_orphan
  );
endinterface

// File: rtl/reg_writeback.sv
// Writeback stage: sole writer of the register file. Retires ALU results and
// in-order load data, tracking outstanding load destinations in a small FIFO.
module reg_writeback #(
  parameter int unsigned LQ_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  reg_writeback_if.slave bus
);
  localparam int unsigned PW = $clog2(LQ_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [4:0]    r_lq [LQ_DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_wen;
  logic [4:0]    r_waddr;
  logic [31:0]   r_wdata;
  logic          r_err;

  logic          w_ready;
  logic          w_push;
  logic          w_pop;
  logic          w_alu;
  logic          w_empty;
  logic [4:0]    w_head;
  logic [31:0]   w_mask;
  logic [PW-1:0] w_off;

  assign w_empty = (r_count == '0);
  assign w_head  = r_lq[r_rd_ptr];

  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin
    w_mask = '0;
    w_off  = '0;
    for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
      w_off = PW'(i) - r_rd_ptr;
      if ({1'b0, w_off} < r_count) w_mask[r_lq[i]] = 1'b1;
    end
    w_mask[0] = 1'b0;
  end

  always_comb begin
    if (bus.ex_is_load) w_ready = (r_count != CW'(LQ_DEPTH));
    else                w_ready = !bus.mem_rsp_valid && !w_mask[bus.ex_rd];
  end

  assign w_push = bus.ex_valid && w_ready && bus.ex_is_load;
  assign w_alu  = bus.ex_valid && w_ready && !bus.ex_is_load;
  assign w_pop  = bus.mem_rsp_valid && !w_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_wen    <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_push) begin
        r_lq[r_wr_ptr] <= bus.ex_rd;
        r_wr_ptr       <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      // ALU retire is impossible while a response is valid, so pop never collides with it.
      if (w_pop) begin
        r_wen   <= (w_head != 5'd0);
        r_waddr <= w_head;
        r_wdata <= bus.mem_rsp_data;
      end else if (w_alu) begin
        r_wen   <= (bus.ex_rd != 5'd0);
        r_waddr <= bus.ex_rd;
        r_wdata <= bus.ex_data;
      end else begin
        r_wen   <= 1'b0;
      end

      if (bus.mem_rsp_valid && w_empty) r_err <= 1'b1;
    end
  end

  assign bus.ex_ready   = w_ready;
  assign bus.wen        = r_wen;
  assign bus.regWAddr   = r_waddr;
  assign bus.regWData   = r_wdata;
  assign bus.pend_mask  = w_mask;
  assign bus.lq_count   = r_count;
  assign bus.err_orphan = r_err;
endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: queue-based reference model, per-cycle
// compare process, directed scenarios with literal expectations, random traffic.
module tb_reg_writeback;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_writeback_if #(.LQ_DEPTH(DEPTH)) bus();
  reg_writeback #(.LQ_DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  logic [4:0]  q[$];
  logic        m_wen;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        m_err;
  logic [31:0] rf [32];
  bit          last_ready;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] mmask();
    logic [31:0] m = '0;
    foreach (q[i]) m[q[i]] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  function automatic bit mready();
    logic [31:0] m;
    if (bus.ex_is_load) return q.size() != DEPTH;
    m = mmask();
    return !bus.mem_rsp_valid && !m[bus.ex_rd];
  endfunction

  task automatic drive(input bit v, input bit ld, input logic [4:0] rd, input logic [31:0] d,
                       input bit rv, input logic [31:0] rdat);
    bus.ex_valid      = v;
    bus.ex_is_load    = ld;
    bus.ex_rd         = rd;
    bus.ex_data       = d;
    bus.mem_rsp_valid = rv;
    bus.mem_rsp_data  = rdat;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
  endtask

  // Advance one clock and apply the architectural rules to the model.
  task automatic step();
    bit r, pop, push, alu;
    logic [4:0] h;
    r = mready();
    last_ready = r;
    @(posedge clk);
    if (reset) begin
      q.delete();
      m_wen = 1'b0; m_addr = '0; m_data = '0; m_err = 1'b0;
    end else begin
      pop  = bus.mem_rsp_valid && (q.size() != 0);
      push = bus.ex_valid && r && bus.ex_is_load;
      alu  = bus.ex_valid && r && !bus.ex_is_load;
      if (bus.mem_rsp_valid && q.size() == 0) m_err = 1'b1;
      if (pop) begin
        h = q.pop_front();
        m_wen = (h != 0); m_addr = h; m_data = bus.mem_rsp_data;
      end else if (alu) begin
        m_wen = (bus.ex_rd != 0); m_addr = bus.ex_rd; m_data = bus.ex_data;
      end else begin
        m_wen = 1'b0;
      end
      if (m_wen) rf[m_addr] = m_data;
      if (push) q.push_back(bus.ex_rd);
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("wen",        {31'd0, bus.wen},        {31'd0, m_wen});
      chk("regWAddr",   {27'd0, bus.regWAddr},   {27'd0, m_addr});
      chk("regWData",   bus.regWData,            m_data);
      chk("lq_count",   32'(bus.lq_count),       32'(q.size()));
      chk("pend_mask",  bus.pend_mask,           mmask());
      chk("err_orphan", {31'd0, bus.err_orphan}, {31'd0, m_err});
      chk("ex_ready",   {31'd0, bus.ex_ready},   {31'd0, mready()});
    end
  end

  initial begin
    foreach (rf[i]) rf[i] = '0;
    reset = 1'b1;
    idle();
    step();
    chk_en = 1'b1;
    chk("rst_wen",   {31'd0, bus.wen}, 32'd0);
    chk("rst_addr",  {27'd0, bus.regWAddr}, 32'd0);
    chk("rst_data",  bus.regWData, 32'd0);
    chk("rst_count", 32'(bus.lq_count), 32'd0);
    chk("rst_mask",  bus.pend_mask, 32'd0);
    chk("rst_err",   {31'd0, bus.err_orphan}, 32'd0);
    step();
    reset = 1'b0;

    // ALU retires, x0 suppressed
    drive(1, 0, 5'd5, 32'hDEADBEEF, 0, 0); step();
    chk("alu1_wen", {31'd0, bus.wen}, 32'd1);
    chk("alu1_addr", {27'd0, bus.regWAddr}, 32'd5);
    chk("alu1_data", bus.regWData, 32'hDEADBEEF);
    drive(1, 0, 5'd0, 32'h1234, 0, 0); step();
    chk("alu_x0_wen", {31'd0, bus.wen}, 32'd0);
    idle(); step();

    // Loads 3,7,3 and in-order responses
    drive(1, 1, 5'd3, 0, 0, 0); step();
    drive(1, 1, 5'd7, 0, 0, 0); step();
    drive(1, 1, 5'd3, 0, 0, 0); step();
    idle();
    chk("ld_mask", bus.pend_mask, 32'h88);
    chk("ld_count", 32'(bus.lq_count), 32'd3);
    drive(0, 0, 0, 0, 1, 32'hA); step();
    chk("rsp1", {bus.wen, 22'd0, bus.regWAddr, bus.regWData[3:0]}, {1'b1, 22'd0, 5'd3, 4'hA});
    drive(0, 0, 0, 0, 1, 32'hB); step();
    chk("rsp2", {bus.wen, 22'd0, bus.regWAddr, bus.regWData[3:0]}, {1'b1, 22'd0, 5'd7, 4'hB});
    drive(0, 0, 0, 0, 1, 32'hC); step();
    chk("rsp3", {bus.wen, 22'd0, bus.regWAddr, bus.regWData[3:0]}, {1'b1, 22'd0, 5'd3, 4'hC});
    idle(); step();
    chk("ld_mask_clr", bus.pend_mask, 32'h0);

    // Queue full, no bypass on same-cycle pop
    drive(1, 1, 5'd1, 0, 0, 0); step();
    drive(1, 1, 5'd2, 0, 0, 0); step();
    drive(1, 1, 5'd4, 0, 0, 0); step();
    drive(1, 1, 5'd6, 0, 0, 0); step();
    chk("full_count", 32'(bus.lq_count), 32'd4);
    drive(1, 1, 5'd8, 0, 0, 0); #1;
    chk("full_ready", {31'd0, bus.ex_ready}, 32'd0);
    step();
    drive(1, 1, 5'd8, 0, 1, 32'h11); #1;
    chk("full_pop_ready", {31'd0, bus.ex_ready}, 32'd0);
    step();
    chk("full_pop_count", 32'(bus.lq_count), 32'd3);
    drive(1, 1, 5'd8, 0, 0, 0); #1;
    chk("full_retry_ready", {31'd0, bus.ex_ready}, 32'd1);
    step();
    chk("full_refill", 32'(bus.lq_count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1, 32'h20 + 32'(i)); step();
    end
    idle(); step();

    // Write-port conflict: memory response wins
    drive(1, 1, 5'd10, 0, 0, 0); step();
    drive(1, 0, 5'd9, 32'h77, 1, 32'h66); #1;
    chk("conf_ready", {31'd0, bus.ex_ready}, 32'd0);
    step();
    chk("conf_mem", {bus.wen, 3'd0, bus.regWAddr, bus.regWData[7:0]}, {1'b1, 3'd0, 5'd10, 8'h66});
    drive(1, 0, 5'd9, 32'h77, 0, 0); step();
    chk("conf_alu", {bus.wen, 3'd0, bus.regWAddr, bus.regWData[7:0]}, {1'b1, 3'd0, 5'd9, 8'h77});
    idle(); step();

    // WAW hold against a pending load
    drive(1, 1, 5'd12, 0, 0, 0); step();
    drive(1, 0, 5'd12, 32'h55, 0, 0); #1;
    chk("waw_ready", {31'd0, bus.ex_ready}, 32'd0);
    step(); step();
    chk("waw_held_wen", {31'd0, bus.wen}, 32'd0);
    drive(1, 0, 5'd12, 32'h55, 1, 32'h99); step();
    chk("waw_load", {bus.wen, 3'd0, bus.regWAddr, bus.regWData[7:0]}, {1'b1, 3'd0, 5'd12, 8'h99});
    drive(1, 0, 5'd12, 32'h55, 0, 0); step();
    chk("waw_alu", {bus.wen, 3'd0, bus.regWAddr, bus.regWData[7:0]}, {1'b1, 3'd0, 5'd12, 8'h55});
    chk("waw_rf12", rf[12], 32'h55);
    idle(); step();

    // Orphan, then reset with loads queued
    drive(0, 0, 0, 0, 1, 32'h1); step();
    chk("orph_err", {31'd0, bus.err_orphan}, 32'd1);
    chk("orph_wen", {31'd0, bus.wen}, 32'd0);
    drive(1, 1, 5'd2, 0, 0, 0); step();
    drive(1, 1, 5'd3, 0, 0, 0); step();
    idle(); reset = 1'b1; step(); reset = 1'b0;
    chk("rst2_count", 32'(bus.lq_count), 32'd0);
    chk("rst2_mask", bus.pend_mask, 32'd0);
    chk("rst2_err", {31'd0, bus.err_orphan}, 32'd0);

    // Random traffic obeying the hold-while-stalled rule
    for (int c = 0; c < 3000; c++) begin
      if (!(bus.ex_valid && !last_ready)) begin
        bus.ex_valid   = ($urandom_range(0, 2) != 0);
        bus.ex_is_load = $urandom_range(0, 1) == 1;
        bus.ex_rd      = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
        bus.ex_data    = $urandom;
      end
      bus.mem_rsp_valid = (q.size() != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0);
      bus.mem_rsp_data  = $urandom;
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;
    idle(); step();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
